dxm_int_service_ctrl: RTL and testbench

- Service sequencer for the interrupt status/mask block.
- Watches latched status and mask, and picks one pending unmasked source by round-robin.
- Presents the source index to the host/CPU-side agent over a valid/ack handshake, then issues the single-cycle write-1-to-clear (clr_status_1p + r_din one-hot) back into the status block.
- An optional programmable holdoff between services provides interrupt coalescing.

---
 rtl/dxm_int_service_ctrl_if.sv | 10 +
 rtl/dxm_int_service_ctrl.sv | 62 ++++++
 tb/tb_dxm_int_service_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dxm_int_service_ctrl_if.sv
// dxm_int_service_ctrl_if: source-index valid/ack handshake between service controller and host agent
interface dxm_int_service_ctrl_if #(
  parameter int IDX_W = 3
);
  logic             svc_valid;
  logic [IDX_W-1:0] svc_idx;
  logic             svc_ack;
  modport master (output svc_valid, output svc_idx, input svc_ack);
  modport slave  (input svc_valid, input svc_idx, output svc_ack);
endinterface

// File: rtl/dxm_int_service_ctrl.sv
// dxm_int_service_ctrl: round-robin interrupt service sequencer with ack handshake, W1C clear strobe and holdoff
module dxm_int_service_ctrl #(
  parameter int VEC_W     = 8,
  parameter int IDX_W     = 3,
  parameter int HOLDOFF_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [VEC_W-1:0]       status,
  input  logic [VEC_W-1:0]       mask,
  input  logic                   enable,
  input  logic [HOLDOFF_W-1:0]   holdoff_cfg,
  dxm_int_service_ctrl_if.master svc,
  output logic                   clr_status_1p,
  output logic [VEC_W-1:0]       clr_vec,
  output logic                   busy
);
  localparam logic [1:0] IDLE = 2'd0, PRESENT = 2'd1, CLEAR = 2'd2, HOLDOFF = 2'd3;
  logic [1:0]           state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr, sel;
  logic [HOLDOFF_W-1:0] cnt;
  logic [VEC_W-1:0]     pending;
  assign pending = status & ~mask;
  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    logic [IDX_W:0] s;
    sel = '0;
    s   = '0;
    for (int k = VEC_W - 1; k >= 0; k--) begin
      s = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      s = (s >= (IDX_W+1)'(VEC_W)) ? s - (IDX_W+1)'(VEC_W) : s;
      sel = pending[s[IDX_W-1:0]] ? s[IDX_W-1:0] : sel;
    end
  end
  always_comb begin
    state_nxt = (state == IDLE)    ? ((enable && |pending) ? PRESENT : IDLE) :
                (state == PRESENT) ? (svc.svc_ack ? CLEAR : PRESENT) :
                (state == CLEAR)   ? ((holdoff_cfg != '0) ? HOLDOFF : IDLE) :
                                     ((cnt <= HOLDOFF_W'(1)) ? IDLE : HOLDOFF);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      svc.svc_valid <= 1'b0;
      svc.svc_idx   <= '0;
      clr_status_1p <= 1'b0;
      clr_vec       <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      busy          <= state_nxt != IDLE;
      svc.svc_valid <= state_nxt == PRESENT;
      clr_status_1p <= state_nxt == CLEAR;
      clr_vec       <= (state_nxt == CLEAR) ? VEC_W'(1) << svc.svc_idx : '0;
      if (state == IDLE && state_nxt == PRESENT) svc.svc_idx <= sel;
      if (state == CLEAR) rr_ptr <= (svc.svc_idx == IDX_W'(VEC_W - 1)) ? '0 : svc.svc_idx + 1'b1;
      cnt <= (state == CLEAR) ? holdoff_cfg : (state == HOLDOFF) ? cnt - 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_dxm_int_service_ctrl.sv
// tb_dxm_int_service_ctrl: directed scenarios plus randomized run against a transaction-level model
module tb_dxm_int_service_ctrl;
  localparam int VEC_W = 8, IDX_W = 3, HOLDOFF_W = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [VEC_W-1:0] status = '0, mask = '0;
  logic enable = 1'b0;
  logic [HOLDOFF_W-1:0] holdoff_cfg = '0;
  logic clr_status_1p, busy;
  logic [VEC_W-1:0] clr_vec;
  int pass_cnt = 0, total = 0;
  dxm_int_service_ctrl_if #(.IDX_W(IDX_W)) svc();
  dxm_int_service_ctrl #(.VEC_W(VEC_W), .IDX_W(IDX_W), .HOLDOFF_W(HOLDOFF_W)) dut (
    .clk(clk), .rst_n(rst_n), .status(status), .mask(mask), .enable(enable),
    .holdoff_cfg(holdoff_cfg), .svc(svc), .clr_status_1p(clr_status_1p),
    .clr_vec(clr_vec), .busy(busy)
  );
  always #5 clk = ~clk;
  bit e_valid, e_clr;
  int e_idx, ptr, hold;
  function automatic int rr_pick(logic [VEC_W-1:0] p, int start);
    for (int k = 0; k < VEC_W; k++) if (p[(start + k) % VEC_W]) return (start + k) % VEC_W;
    return -1;
  endfunction
  task automatic model_reset();
    e_valid = 0; e_clr = 0; e_idx = 0; ptr = 0; hold = 0;
  endtask
  task automatic step();
    logic [VEC_W-1:0] p;
    @(posedge clk);
    p = status & ~mask;
    if (!rst_n) model_reset();
    else if (e_clr) begin ptr = (e_idx + 1) % VEC_W; hold = int'(holdoff_cfg); e_clr = 0; end
    else if (hold > 0) hold--;
    else if (e_valid) begin if (svc.svc_ack) begin e_valid = 0; e_clr = 1; end end
    else if (enable && p != '0) begin e_idx = rr_pick(p, ptr); e_valid = 1; end
    @(negedge clk);
  endtask
  task automatic apply_reset();
    rst_n = 1'b0; status = '0; mask = '0; enable = 1'b1; holdoff_cfg = '0; svc.svc_ack = 1'b0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
  endtask
  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 12 && !svc.svc_valid; i++) step();
    ok = svc.svc_valid;
  endtask
  task automatic test_reset();
    apply_reset();
    total++;
    if ({svc.svc_valid, svc.svc_idx, clr_status_1p, clr_vec, busy} !== '0)
      $display("FAIL reset_values got v=%b i=%0d c=%b cv=%h b=%b exp all 0", svc.svc_valid, svc.svc_idx, clr_status_1p, clr_vec, busy);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if ({svc.svc_valid, clr_status_1p, busy} !== 3'b000)
        $display("FAIL idle_quiet cyc=%0d got v/c/b=%b exp 000", i, {svc.svc_valid, clr_status_1p, busy});
      else pass_cnt++;
    end
  endtask
  task automatic test_single();
    apply_reset();
    status = 8'h10;
    step();
    total++;
    if (svc.svc_valid !== 1'b1 || svc.svc_idx !== 3'd4)
      $display("FAIL single_present got v=%b i=%0d exp v=1 i=4", svc.svc_valid, svc.svc_idx);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (svc.svc_valid !== 1'b1 || svc.svc_idx !== 3'd4 || clr_status_1p !== 1'b0)
        $display("FAIL single_hold cyc=%0d got v=%b i=%0d c=%b exp v=1 i=4 c=0", i, svc.svc_valid, svc.svc_idx, clr_status_1p);
      else pass_cnt++;
    end
    svc.svc_ack = 1'b1;
    step();
    svc.svc_ack = 1'b0; status = '0;
    total++;
    if (svc.svc_valid !== 1'b0 || clr_status_1p !== 1'b1 || clr_vec !== 8'h10 || busy !== 1'b1)
      $display("FAIL single_clear got v=%b c=%b cv=%h b=%b exp v=0 c=1 cv=10 b=1", svc.svc_valid, clr_status_1p, clr_vec, busy);
    else pass_cnt++;
    step();
    total++;
    if (clr_status_1p !== 1'b0 || clr_vec !== 8'h00 || busy !== 1'b0)
      $display("FAIL single_after got c=%b cv=%h b=%b exp c=0 cv=00 b=0", clr_status_1p, clr_vec, busy);
    else pass_cnt++;
  endtask
  task automatic test_round_robin();
    bit ok;
    apply_reset();
    status = 8'h81; svc.svc_ack = 1'b1;
    for (int n = 0; n < 6; n++) begin
      wait_valid(ok);
      total++;
      if (!ok) $display("FAIL rr_timeout svc=%0d got no valid exp valid", n);
      else if (svc.svc_idx !== ((n % 2) ? 3'd7 : 3'd0))
        $display("FAIL rr_idx svc=%0d got %0d exp %0d", n, svc.svc_idx, (n % 2) ? 7 : 0);
      else pass_cnt++;
      step();
      total++;
      if (clr_status_1p !== 1'b1 || clr_vec !== ((n % 2) ? 8'h80 : 8'h01))
        $display("FAIL rr_clear svc=%0d got c=%b cv=%h exp c=1 cv=%h", n, clr_status_1p, clr_vec, (n % 2) ? 8'h80 : 8'h01);
      else pass_cnt++;
    end
    svc.svc_ack = 1'b0; status = '0;
    step(); step();
  endtask
  task automatic test_masking();
    apply_reset();
    status = 8'h06; mask = 8'h02;
    step();
    total++;
    if (svc.svc_valid !== 1'b1 || svc.svc_idx !== 3'd2)
      $display("FAIL mask_select got v=%b i=%0d exp v=1 i=2", svc.svc_valid, svc.svc_idx);
    else pass_cnt++;
    mask = 8'h06; enable = 1'b0;
    step(); step();
    total++;
    if (svc.svc_valid !== 1'b1 || svc.svc_idx !== 3'd2)
      $display("FAIL mask_no_abort got v=%b i=%0d exp v=1 i=2", svc.svc_valid, svc.svc_idx);
    else pass_cnt++;
    svc.svc_ack = 1'b1; enable = 1'b1;
    step();
    svc.svc_ack = 1'b0; status = 8'h02;
    total++;
    if (clr_status_1p !== 1'b1 || clr_vec !== 8'h04)
      $display("FAIL mask_clear got c=%b cv=%h exp c=1 cv=04", clr_status_1p, clr_vec);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (svc.svc_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL mask_quiet cyc=%0d got v=%b b=%b exp v=0 b=0", i, svc.svc_valid, busy);
      else pass_cnt++;
    end
  endtask
  task automatic test_holdoff();
    int gap;
    apply_reset();
    holdoff_cfg = 8'd3; status = 8'h03; svc.svc_ack = 1'b1;
    step(); step();
    status = 8'h02;
    total++;
    if (clr_status_1p !== 1'b1 || clr_vec !== 8'h01)
      $display("FAIL hold_clear0 got c=%b cv=%h exp c=1 cv=01", clr_status_1p, clr_vec);
    else pass_cnt++;
    gap = 0;
    for (int i = 0; i < 20 && !svc.svc_valid; i++) begin
      step();
      if (busy && !svc.svc_valid) gap++;
    end
    total++;
    if (!svc.svc_valid) $display("FAIL hold_timeout got no valid exp valid");
    else if (gap != 3 || svc.svc_idx !== 3'd1)
      $display("FAIL hold_gap got gap=%0d i=%0d exp gap=3 i=1", gap, svc.svc_idx);
    else pass_cnt++;
    svc.svc_ack = 1'b0; status = '0; holdoff_cfg = '0;
    for (int i = 0; i < 6; i++) step();
  endtask
  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    status = 8'h03; svc.svc_ack = 1'b1;
    step(); step();
    svc.svc_ack = 1'b0;
    wait_valid(ok);
    total++;
    if (!ok || svc.svc_idx !== 3'd1)
      $display("FAIL rstmid_setup got v=%b i=%0d exp v=1 i=1", svc.svc_valid, svc.svc_idx);
    else pass_cnt++;
    svc.svc_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({svc.svc_valid, svc.svc_idx, clr_status_1p, clr_vec, busy} !== '0)
      $display("FAIL rstmid_async got v=%b i=%0d c=%b cv=%h b=%b exp all 0", svc.svc_valid, svc.svc_idx, clr_status_1p, clr_vec, busy);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (clr_status_1p !== 1'b0 || busy !== 1'b0)
        $display("FAIL rstmid_noclr cyc=%0d got c=%b b=%b exp c=0 b=0", i, clr_status_1p, busy);
      else pass_cnt++;
    end
    svc.svc_ack = 1'b0;
    rst_n = 1'b1;
    step();
    total++;
    if (svc.svc_valid !== 1'b1 || svc.svc_idx !== 3'd0)
      $display("FAIL rstmid_ptr got v=%b i=%0d exp v=1 i=0", svc.svc_valid, svc.svc_idx);
    else pass_cnt++;
  endtask
  task automatic test_random();
    logic [VEC_W-1:0] ev;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      status = ($urandom_range(0, 3) == 0) ? '0 : VEC_W'($urandom);
      mask = VEC_W'($urandom & $urandom);
      enable = $urandom_range(0, 3) != 0;
      svc.svc_ack = 1'($urandom);
      if ($urandom_range(0, 7) == 0) holdoff_cfg = HOLDOFF_W'($urandom_range(0, 4));
      step();
      ev = e_clr ? VEC_W'(1) << e_idx : '0;
      total++;
      if (svc.svc_valid !== e_valid) $display("FAIL rnd_valid cyc=%0d got %b exp %b", c, svc.svc_valid, e_valid);
      else pass_cnt++;
      if (e_valid) begin
        total++;
        if (svc.svc_idx !== IDX_W'(e_idx)) $display("FAIL rnd_idx cyc=%0d got %0d exp %0d", c, svc.svc_idx, e_idx);
        else pass_cnt++;
      end
      total++;
      if (clr_status_1p !== e_clr || clr_vec !== ev)
        $display("FAIL rnd_clear cyc=%0d got c=%b cv=%h exp c=%b cv=%h", c, clr_status_1p, clr_vec, e_clr, ev);
      else pass_cnt++;
      total++;
      if (busy !== (e_valid || e_clr || hold > 0)) $display("FAIL rnd_busy cyc=%0d got %b exp %b", c, busy, e_valid || e_clr || hold > 0);
      else pass_cnt++;
    end
  endtask
  initial begin
    svc.svc_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_masking();
    test_holdoff();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
